sobel_frame_ctrl: RTL and testbench



---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_scan_cnt.sv | 49 ++++
 rtl/sobel_frame_ctrl.sv | 112 +++++++++++
 tb/tb_sobel_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared state encoding and pixel classification for the sobel frame sequencer
// Contents: STATE_W, ST_IDLE..ST_DONE state codes, is_border() edge-pixel test.
package sobel_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_GRAY  = 3'd1;
  localparam logic [STATE_W-1:0] ST_GAP   = 3'd2;
  localparam logic [STATE_W-1:0] ST_SOBEL = 3'd3;
  localparam logic [STATE_W-1:0] ST_FLUSH = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  // A pixel on the outer ring has no full 3x3 neighbourhood, so it is written as 0.
  function automatic logic is_border(input int row, input int col, input int w, input int h);
    return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
  endfunction

endpackage

// File: rtl/sobel_scan_cnt.sv
// rtl/sobel_scan_cnt.sv - raster row/col/linear-address counter with enable, clear and last flag
// Ports: clk, rst (sync, active-high), clr (return to pixel 0), en (advance one pixel),
//        row/col (raster position, col fastest), addr (row*IMG_W+col), last (at final pixel).
module sobel_scan_cnt #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic [ADDR_W-1:0]          addr,
  output logic                       last
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic col_end;

  assign col_end = (col == COL_W'(IMG_W - 1));
  assign last    = col_end && (row == ROW_W'(IMG_H - 1));

  // The linear address is stepped alongside row/col so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (en) begin
      if (last) begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end else if (col_end) begin
        row  <= row + ROW_W'(1);
        col  <= '0;
        addr <= addr + ADDR_W'(1);
      end else begin
        col  <= col + COL_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame sequencer: gray pass, drain, sobel pass, drain, done
// Ports: clk, rst (sync, active-high), start (frame request, IDLE only), stall (scan hold);
//        gray_en/gray_addr (gray pass), sobel_en/border_en/sobel_row/sobel_col/sobel_addr
//        (sobel pass), busy, done (1-cycle pulse), state (debug), frame_cnt (completed frames).
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int ADDR_W    = 12,
  parameter int GRAY_LAT  = 2,
  parameter int SOBEL_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stall,
  output logic                       gray_en,
  output logic [ADDR_W-1:0]          gray_addr,
  output logic                       sobel_en,
  output logic                       border_en,
  output logic [$clog2(IMG_H)-1:0]   sobel_row,
  output logic [$clog2(IMG_W)-1:0]   sobel_col,
  output logic [ADDR_W-1:0]          sobel_addr,
  output logic                       busy,
  output logic                       done,
  output logic [STATE_W-1:0]         state,
  output logic [7:0]                 frame_cnt
);

  localparam int MAX_LAT = (GRAY_LAT > SOBEL_LAT) ? GRAY_LAT : SOBEL_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT) + 1;

  logic [LAT_W-1:0] lat;
  logic             lat_zero;
  logic             scan_en;
  logic             scan_clr;
  logic             scan_last;
  logic             sobel_go;
  logic             on_border;

  assign lat_zero = (lat == '0);

  // The two passes never overlap, so one raster counter serves both.
  assign scan_en  = ((state == ST_GRAY) || (state == ST_SOBEL)) && !stall;
  assign scan_clr = ((state == ST_IDLE) && start) || ((state == ST_GAP) && lat_zero);

  sobel_scan_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clr  (scan_clr),
    .en   (scan_en),
    .row  (sobel_row),
    .col  (sobel_col),
    .addr (sobel_addr),
    .last (scan_last)
  );

  assign gray_addr = sobel_addr;
  assign on_border = is_border(int'(sobel_row), int'(sobel_col), IMG_W, IMG_H);
  assign sobel_go  = (state == ST_SOBEL) && !stall;
  assign gray_en   = (state == ST_GRAY) && !stall;
  assign sobel_en  = sobel_go && !on_border;
  assign border_en = sobel_go && on_border;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // GAP and FLUSH count down a loaded latency and ignore stall: the datapath drains regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat       <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_GRAY;
        end
        ST_GRAY: begin
          if (!stall && scan_last) begin
            state <= ST_GAP;
            lat   <= LAT_W'(GRAY_LAT - 1);
          end
        end
        ST_GAP: begin
          if (lat_zero) state <= ST_SOBEL;
          else          lat   <= lat - LAT_W'(1);
        end
        ST_SOBEL: begin
          if (!stall && scan_last) begin
            state <= ST_FLUSH;
            lat   <= LAT_W'(SOBEL_LAT - 1);
          end
        end
        ST_FLUSH: begin
          if (lat_zero) state <= ST_DONE;
          else          lat   <= lat - LAT_W'(1);
        end
        ST_DONE: begin
          frame_cnt <= frame_cnt + 8'd1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - self-checking bench for sobel_frame_ctrl on a 4x4 frame
module tb_sobel_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int GL = 2;
  localparam int SL = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stall;
  logic       gray_en;
  logic [3:0] gray_addr;
  logic       sobel_en;
  logic       border_en;
  logic [1:0] sobel_row;
  logic [1:0] sobel_col;
  logic [3:0] sobel_addr;
  logic       busy;
  logic       done;
  logic [2:0] state;
  logic [7:0] frame_cnt;

  sobel_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(4), .GRAY_LAT(GL), .SOBEL_LAT(SL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .gray_en(gray_en), .gray_addr(gray_addr),
    .sobel_en(sobel_en), .border_en(border_en),
    .sobel_row(sobel_row), .sobel_col(sobel_col), .sobel_addr(sobel_addr),
    .busy(busy), .done(done), .state(state), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: the whole unstalled frame as a list of expected cycles; a stall on a scan
  // cycle repeats that cycle with enables forced low.
  typedef struct {
    int st;
    int addr;
    int row;
    int col;
    int g;
    int s;
    int b;
  } ent_t;

  ent_t mq[$];
  ent_t me;
  int   m_fcnt = 0;
  bit   model_on = 0;
  bit   m_hold;

  task automatic load_frame();
    ent_t e;
    for (int p = 0; p < W * H; p++) begin
      e = '{st: 1, addr: p, row: 0, col: 0, g: 1, s: 0, b: 0};
      mq.push_back(e);
    end
    for (int i = 0; i < GL; i++) begin
      e = '{st: 2, addr: 0, row: 0, col: 0, g: 0, s: 0, b: 0};
      mq.push_back(e);
    end
    for (int p = 0; p < W * H; p++) begin
      int r, c, inner;
      r = p / W;
      c = p % W;
      inner = (r > 0 && r < H - 1 && c > 0 && c < W - 1) ? 1 : 0;
      e = '{st: 3, addr: p, row: r, col: c, g: 0, s: inner, b: 1 - inner};
      mq.push_back(e);
    end
    for (int i = 0; i < SL; i++) begin
      e = '{st: 4, addr: 0, row: 0, col: 0, g: 0, s: 0, b: 0};
      mq.push_back(e);
    end
    e = '{st: 5, addr: 0, row: 0, col: 0, g: 0, s: 0, b: 0};
    mq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      if (mq.size() == 0) me = '{st: 0, addr: 0, row: 0, col: 0, g: 0, s: 0, b: 0};
      else                me = mq[0];
      m_hold = ((me.st == 1) || (me.st == 3)) && stall;
      chk("state",     int'(state),     me.st);
      chk("busy",      int'(busy),      (me.st != 0) ? 1 : 0);
      chk("done",      int'(done),      (me.st == 5) ? 1 : 0);
      chk("frame_cnt", int'(frame_cnt), m_fcnt);
      chk("gray_en",   int'(gray_en),   m_hold ? 0 : me.g);
      chk("sobel_en",  int'(sobel_en),  m_hold ? 0 : me.s);
      chk("border_en", int'(border_en), m_hold ? 0 : me.b);
      if (me.st == 1) chk("gray_addr", int'(gray_addr), me.addr);
      if (me.st == 3) begin
        chk("sobel_addr", int'(sobel_addr), me.addr);
        chk("sobel_row",  int'(sobel_row),  me.row);
        chk("sobel_col",  int'(sobel_col),  me.col);
      end
      if (rst) begin
        mq.delete();
        m_fcnt = 0;
      end else if (mq.size() == 0) begin
        if (start) load_frame();
      end else if (!m_hold) begin
        if (me.st == 5) m_fcnt = (m_fcnt + 1) % 256;
        void'(mq.pop_front());
      end
    end
  end

  // Side monitor for the hand-computed first-frame expectations.
  bit collect = 0;
  int sob_q[$];
  int n_gray = 0;
  int n_border = 0;
  int n_done = 0;
  always @(negedge clk) begin
    if (collect) begin
      if (sobel_en)  sob_q.push_back(int'(sobel_addr));
      if (border_en) n_border++;
      if (gray_en)   n_gray++;
      if (done)      n_done++;
    end
  end

  int t0 = 0;

  task automatic start_frame();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("done_timeout", 0, 1);
  endtask

  int c1, c2;
  int exp_sob[4];

  initial begin
    exp_sob[0] = 5; exp_sob[1] = 6; exp_sob[2] = 9; exp_sob[3] = 10;
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gray_addr", int'(gray_addr), 0);
    chk("rst_sobel_addr", int'(sobel_addr), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    model_on = 1'b1;

    // Frame 1: no stall.
    collect = 1'b1;
    start_frame();
    wait_done(c1);
    chk("f1_done_cycle", c1 - t0 + 1, 38);
    @(posedge clk);
    #1 collect = 1'b0;
    chk("f1_gray_cnt", n_gray, 16);
    chk("f1_border_cnt", n_border, 12);
    chk("f1_sobel_cnt", sob_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("f1_sobel_addr", (i < sob_q.size()) ? sob_q[i] : -1, exp_sob[i]);
    chk("f1_frame_cnt", int'(frame_cnt), 1);

    // Frame 2: stall 3 cycles while gray_addr is 7 (cycles 8..10).
    start_frame();
    fork
      begin
        repeat (7) @(posedge clk);
        #1 stall = 1'b1;
        chk("f2_stall_addr", int'(gray_addr), 7);
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
      end
      wait_done(c1);
    join
    chk("f2_done_cycle", c1 - t0 + 1, 41);

    // Frame 3: stall through GAP (17-18) and FLUSH (35-37) has no effect.
    start_frame();
    fork
      begin
        repeat (16) @(posedge clk);
        #1 stall = 1'b1;
        repeat (2) @(posedge clk);
        #1 stall = 1'b0;
        repeat (16) @(posedge clk);
        #1 stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
      end
      wait_done(c1);
    join
    chk("f3_done_cycle", c1 - t0 + 1, 38);

    // Frames 4-5: start held high, one IDLE cycle between frames.
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    wait_done(c1);
    chk("b2b_first_done", c1 - t0 + 1, 38);
    wait_done(c2);
    chk("b2b_interval", c2 - c1, 39);
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_frame_cnt", int'(frame_cnt), 5);

    // Reset during SOBEL at address 9 (cycle 28).
    start_frame();
    repeat (27) @(posedge clk);
    #1 chk("rst_pre_addr", int'(sobel_addr), 9);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_sobel_addr", int'(sobel_addr), 0);
    chk("mid_rst_row_col", int'({sobel_row, sobel_col}), 0);
    chk("mid_rst_enables", int'({gray_en, sobel_en, border_en, busy, done}), 0);
    chk("mid_rst_frame_cnt", int'(frame_cnt), 0);
    n_done = 0;
    collect = 1'b1;
    repeat (60) @(posedge clk);
    #1 collect = 1'b0;
    chk("mid_rst_no_done", n_done, 0);

    // 256 frames: frame_cnt wraps to 0 on the 256th done.
    @(posedge clk);
    #1 start = 1'b1;
    for (int f = 1; f <= 256; f++) begin
      wait_done(c1);
      if (f == 255) begin
        @(negedge clk);
        chk("wrap_fcnt_255", int'(frame_cnt), 255);
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("wrap_fcnt_0", int'(frame_cnt), 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
